// File: rtl/rotate_seq_ctrl.sv
// Command sequencer around a DW-bit rotate register: load, multi-step
// rotate right/left, and rotate-right search for the first set bit.
module rotate_seq_ctrl #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          sync_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic [AW-1:0] cmd_amt,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rot_cnt,
  output logic          found
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = AW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_SEEK,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] amt, amt_nxt;
  logic          dir_left, dir_left_nxt;
  logic [DW-1:0] q_nxt;
  logic [AW-1:0] rot_cnt_nxt;
  logic          found_nxt;

  logic [DW-1:0] rotr_c;
  logic [DW-1:0] rotl_c;

  // One-step rotations of the current register contents
  assign rotr_c = {q[0], q[DW-1:1]};
  assign rotl_c = {q[DW-2:0], q[DW-1]};

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      amt       <= '0;
      dir_left  <= 1'b0;
      q         <= '0;
      rot_cnt   <= '0;
      found     <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      amt       <= amt_nxt;
      dir_left  <= dir_left_nxt;
      q         <= q_nxt;
      rot_cnt   <= rot_cnt_nxt;
      found     <= found_nxt;
      done      <= (state_nxt == S_DONE);
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    amt_nxt      = amt;
    dir_left_nxt = dir_left;
    q_nxt        = q;
    rot_cnt_nxt  = rot_cnt;
    found_nxt    = found;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD: begin
              q_nxt     = cmd_data;
              state_nxt = S_DONE;
            end
            OP_ROTR, OP_ROTL: begin
              cnt_nxt      = cmd_amt;
              amt_nxt      = cmd_amt;
              dir_left_nxt = (cmd_op == OP_ROTL);
              if (cmd_amt == '0) begin
                rot_cnt_nxt = '0;
                state_nxt   = S_DONE;
              end else begin
                state_nxt = S_ROT;
              end
            end
            OP_SEEK: begin
              cnt_nxt   = '0;
              state_nxt = S_SEEK;
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end

      S_ROT: begin
        q_nxt   = dir_left ? rotl_c : rotr_c;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          rot_cnt_nxt = amt;
          state_nxt   = S_DONE;
        end
      end

      // A miss rotates once more on the last step so q returns to its start value
      S_SEEK: begin
        if (q[0]) begin
          found_nxt   = 1'b1;
          rot_cnt_nxt = cnt;
          state_nxt   = S_DONE;
        end else if (cnt == CNT_LAST) begin
          q_nxt       = rotr_c;
          found_nxt   = 1'b0;
          rot_cnt_nxt = '0;
          state_nxt   = S_DONE;
        end else begin
          q_nxt   = rotr_c;
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Randomized scoreboard bench for rotate_seq_ctrl with an arithmetic reference model.
module tb_rotate_seq_ctrl;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          sync_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_amt;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;
  logic [AW-1:0] rot_cnt;
  logic          found;

  rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt), .q(q), .busy(busy),
    .done(done), .rot_cnt(rot_cnt), .found(found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [AW-1:0] rc;
    logic          fnd;
    int unsigned   due;
  } exp_t;

  exp_t          sbq[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_fail = 0;
  int unsigned   cyc = 0;
  logic          mon_en = 1'b0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] m_q = '0;
  logic [AW-1:0] m_rc = '0;
  logic          m_fnd = 1'b0;
  logic [DW-1:0] idle_q = '0;
  logic [AW-1:0] idle_rc = '0;
  logic          idle_fnd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ror(input logic [DW-1:0] v, input int unsigned k);
    int unsigned x, s;
    s = k % DW;
    x = 32'(v);
    x = ((x >> s) | (x << (DW - s))) & ((32'd1 << DW) - 1);
    return DW'(x);
  endfunction

  function automatic logic [DW-1:0] rol(input logic [DW-1:0] v, input int unsigned k);
    return ror(v, (DW - (k % DW)) % DW);
  endfunction

  // Reference behaviour of one command; e0 is the accept-edge index
  task automatic model_accept(input logic [1:0] op, input logic [DW-1:0] d,
                              input logic [AW-1:0] a, input int unsigned e0);
    int unsigned lat;
    int unsigned p;
    exp_t e;
    lat = 0;
    case (op)
      2'b00: m_q = d;
      2'b01: begin m_q = ror(m_q, a); m_rc = a; lat = a; end
      2'b10: begin m_q = rol(m_q, a); m_rc = a; lat = a; end
      default: begin
        if (m_q == '0) begin
          m_fnd = 1'b0; m_rc = '0; lat = DW;
        end else begin
          p = 0;
          while (((32'(m_q) >> p) & 1) == 0) p++;
          m_q = ror(m_q, p); m_fnd = 1'b1; m_rc = AW'(p); lat = p + 1;
        end
      end
    endcase
    e.q = m_q; e.rc = m_rc; e.fnd = m_fnd; e.due = e0 + lat;
    sbq.push_back(e);
  endtask

  // Monitor: compares every done pulse and idle-state outputs against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
      if (prev_done) check("ready_after_done", 32'(cmd_ready), 32'd1);
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done @cyc %0d: got done=1 expected no pending command", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_q", 32'(q), 32'(e.q));
          check("done_rot_cnt", 32'(rot_cnt), 32'(e.rc));
          check("done_found", 32'(found), 32'(e.fnd));
          check("done_cycle", cyc, e.due);
          check("ready_in_done", 32'(cmd_ready), 32'd0);
          idle_q = e.q; idle_rc = e.rc; idle_fnd = e.fnd;
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        n_cmp++; n_fail++;
        $display("FAIL missing_done @cyc %0d: got no done expected at cyc %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (cmd_ready && !done) begin
        check("idle_q", 32'(q), 32'(idle_q));
        check("idle_rot_cnt", 32'(rot_cnt), 32'(idle_rc));
        check("idle_found", 32'(found), 32'(idle_fnd));
      end
      prev_done = done;
    end
  end

  task automatic post_reset_checks();
    check("rst_q", 32'(q), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_rot_cnt", 32'(rot_cnt), 32'd0);
  endtask

  // Called at a negedge: reset at the next edge, then verify and resume
  task automatic mid_reset();
    sync_rst_n = 1'b0;
    cmd_valid = 1'b0;
    mon_en = 1'b0;
    sbq.delete();
    @(negedge clk);
    post_reset_checks();
    sync_rst_n = 1'b1;
    m_q = '0; m_rc = '0; m_fnd = 1'b0;
    idle_q = '0; idle_rc = '0; idle_fnd = 1'b0;
    prev_done = 1'b0;
    mon_en = 1'b1;
  endtask

  // Present a command until accepted; valid stays high for the caller to drop
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_amt = a;
      if (cmd_ready) begin
        model_accept(op, d, a, cyc + 1);
        return;
      end
    end
    n_cmp++; n_fail++;
    $display("FAIL issue_timeout @cyc %0d: got cmd_ready=0 expected 1", cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (sbq.size() == 0 && cmd_ready) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL idle_timeout @cyc %0d: got %0d pending expected 0", cyc, sbq.size());
  endtask

  initial begin
    sync_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_amt = '0;
    repeat (2) @(negedge clk);
    sync_rst_n = 1'b1;
    post_reset_checks();
    mon_en = 1'b1;

    issue(2'b00, 4'b1001, 2'd0); wait_idle();
    issue(2'b10, 4'b0000, 2'd3); wait_idle();
    check("rotl3_q", 32'(q), 32'hC);
    issue(2'b01, 4'b0000, 2'd1); wait_idle();
    check("rotr1_q", 32'(q), 32'h6);
    issue(2'b01, 4'b1111, 2'd0); wait_idle();
    issue(2'b00, 4'b0100, 2'd0); wait_idle();
    issue(2'b11, 4'b0000, 2'd0); wait_idle();
    check("seek_hit_rc", 32'(rot_cnt), 32'd2);
    issue(2'b00, 4'b0000, 2'd0); wait_idle();
    issue(2'b11, 4'b0000, 2'd0); wait_idle();
    check("seek_miss_found", 32'(found), 32'd0);

    issue(2'b00, 4'b1001, 2'd0); wait_idle();
    issue(2'b10, 4'b0000, 2'd3);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    check("rotl_e1_q", 32'(q), 32'h3);
    mid_reset();

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!cmd_ready && $urandom_range(0, 60) == 0) begin
        mid_reset();
      end else begin
        cmd_valid = ($urandom_range(0, 9) < 7);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = DW'($urandom);
        cmd_amt   = AW'($urandom);
        if (cmd_valid && cmd_ready) model_accept(cmd_op, cmd_data, cmd_amt, cyc + 1);
      end
    end
    wait_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
